// File: rtl/bus_char_writer.sv
// Purpose: 6502 bus slave that turns CPU register writes into text-buffer write strobes, with a hardware screen clear.
// Latency: a bus write strobes wr_en_out on the 4th clk_in edge after ext_clock is first sampled low.
// Backpressure: none; the buffer always accepts, and character/clear writes arriving during a clear are dropped.
//
// Ports:
//   clk_in, rst_n_in             pixel-domain clock, async active-low reset
//   ext_clock, chip_enable,      asynchronous 6502 bus (PHI2, select, R/W,
//   read_write, address, data_in register select, data)
//   wr_addr_out/_data_out/_en_out buffer write port (address = row*COLS + col)
//   busy_out                      high while the clear sequencer runs
//   cursor_col_out/_row_out       current text cursor
module bus_char_writer #(
    parameter int          COLS       = 100,
    parameter int          ROWS       = 75,
    parameter int          ADDR_W     = 13,
    parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              ext_clock,
    input  logic              chip_enable,
    input  logic              read_write,
    input  logic [1:0]        address,
    input  logic [7:0]        data_in,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [7:0]        wr_data_out,
    output logic              wr_en_out,
    output logic              busy_out,
    output logic [6:0]        cursor_col_out,
    output logic [6:0]        cursor_row_out
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [6:0]        COL_MAX  = 7'(COLS - 1);
    localparam logic [6:0]        ROW_MAX  = 7'(ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(COLS * ROWS - 1);

    // Two-flop synchronisers plus one extra PHI2 stage for edge detection
    logic       phi_s1, phi_sync, phi_d;
    logic       ce_s1, ce_sync, rw_s1, rw_sync;
    logic [1:0] addr_s1, addr_sync;
    logic [7:0] data_s1, data_sync;

    // Bus hold register: last values seen while PHI2 was high
    logic       h_ce, h_rw;
    logic [1:0] h_addr;
    logic [7:0] h_data;

    // Registered transaction, acted on in the cycle after bus_fall
    logic       wr_pend;
    logic [1:0] pend_addr;
    logic [7:0] pend_data;

    state_t            state, state_nx;
    logic [6:0]        col, row, col_nx, row_nx;
    logic [ADDR_W-1:0] clr_cnt, clr_nx;
    logic              wr_en_nx, busy_nx;
    logic [ADDR_W-1:0] wr_addr_nx;
    logic [7:0]        wr_data_nx;

    logic              bus_fall;
    logic [6:0]        col_ld, row_ld;
    logic [ADDR_W-1:0] cell_addr;

    assign bus_fall  = phi_d & ~phi_sync;
    assign col_ld    = (pend_data[6:0] > COL_MAX) ? COL_MAX : pend_data[6:0];
    assign row_ld    = (pend_data[6:0] > ROW_MAX) ? ROW_MAX : pend_data[6:0];
    assign cell_addr = ADDR_W'(row) * COLS_A + ADDR_W'(col);

    assign cursor_col_out = col;
    assign cursor_row_out = row;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            phi_s1    <= 1'b0;
            phi_sync  <= 1'b0;
            phi_d     <= 1'b0;
            ce_s1     <= 1'b0;
            ce_sync   <= 1'b0;
            rw_s1     <= 1'b0;
            rw_sync   <= 1'b0;
            addr_s1   <= '0;
            addr_sync <= '0;
            data_s1   <= '0;
            data_sync <= '0;
            h_ce      <= 1'b0;
            h_rw      <= 1'b0;
            h_addr    <= '0;
            h_data    <= '0;
            wr_pend   <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
        end else begin
            phi_s1    <= ext_clock;
            phi_sync  <= phi_s1;
            phi_d     <= phi_sync;
            ce_s1     <= chip_enable;
            ce_sync   <= ce_s1;
            rw_s1     <= read_write;
            rw_sync   <= rw_s1;
            addr_s1   <= address;
            addr_sync <= addr_s1;
            data_s1   <= data_in;
            data_sync <= data_s1;
            if (phi_sync) begin
                h_ce   <= ce_sync;
                h_rw   <= rw_sync;
                h_addr <= addr_sync;
                h_data <= data_sync;
            end
            wr_pend   <= bus_fall & h_ce & ~h_rw;
            pend_addr <= h_addr;
            pend_data <= h_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            clr_cnt     <= '0;
            wr_en_out   <= 1'b0;
            wr_addr_out <= '0;
            wr_data_out <= '0;
            busy_out    <= 1'b0;
        end else begin
            state       <= state_nx;
            col         <= col_nx;
            row         <= row_nx;
            clr_cnt     <= clr_nx;
            wr_en_out   <= wr_en_nx;
            wr_addr_out <= wr_addr_nx;
            wr_data_out <= wr_data_nx;
            busy_out    <= busy_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        col_nx     = col;
        row_nx     = row;
        clr_nx     = clr_cnt;
        wr_en_nx   = 1'b0;
        wr_addr_nx = wr_addr_out;
        wr_data_nx = wr_data_out;
        busy_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (wr_pend) begin
                    case (pend_addr)
                        2'd0: col_nx = col_ld;
                        2'd1: row_nx = row_ld;
                        2'd2: begin
                            wr_en_nx   = 1'b1;
                            wr_addr_nx = cell_addr;
                            wr_data_nx = pend_data;
                            if (col == COL_MAX) begin
                                col_nx = '0;
                                row_nx = (row == ROW_MAX) ? 7'd0 : row + 7'd1;
                            end else begin
                                col_nx = col + 7'd1;
                            end
                        end
                        2'd3: begin
                            // Clear takes priority; its end homes the cursor anyway
                            if (pend_data[0]) begin
                                state_nx = CLEAR;
                                clr_nx   = '0;
                            end else if (pend_data[1]) begin
                                col_nx = '0;
                                row_nx = '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            CLEAR: begin
                // busy_out is registered alongside the strobe so both cover the same cycles
                wr_en_nx   = 1'b1;
                wr_addr_nx = clr_cnt;
                wr_data_nx = CLEAR_CHAR;
                busy_nx    = 1'b1;
                clr_nx     = clr_cnt + 1'b1;
                if (wr_pend && pend_addr == 2'd0) col_nx = col_ld;
                if (wr_pend && pend_addr == 2'd1) row_nx = row_ld;
                if (clr_cnt == CLR_LAST) begin
                    state_nx = IDLE;
                    clr_nx   = '0;
                    col_nx   = '0;
                    row_nx   = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_char_writer.sv
// Purpose: self-checking bench for bus_char_writer using a write scoreboard.
// Latency: expected buffer writes are queued at stimulus time and matched in order as strobes appear.
// Backpressure: none; the bench only observes the write port.
`timescale 1ns/100ps
module tb_bus_char_writer;

    localparam int COLS = 100;
    localparam int ROWS = 75;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        ext_clock = 1'b0;
    logic        chip_enable = 1'b0;
    logic        read_write = 1'b1;
    logic [1:0]  address = '0;
    logic [7:0]  data_in = '0;
    logic [12:0] wr_addr_out;
    logic [7:0]  wr_data_out;
    logic        wr_en_out;
    logic        busy_out;
    logic [6:0]  cursor_col_out;
    logic [6:0]  cursor_row_out;

    bus_char_writer dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .ext_clock      (ext_clock),
        .chip_enable    (chip_enable),
        .read_write     (read_write),
        .address        (address),
        .data_in        (data_in),
        .wr_addr_out    (wr_addr_out),
        .wr_data_out    (wr_data_out),
        .wr_en_out      (wr_en_out),
        .busy_out       (busy_out),
        .cursor_col_out (cursor_col_out),
        .cursor_row_out (cursor_row_out)
    );

    always #12.5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cnt = 0;
    int gap_cnt  = 0;
    logic [20:0] exp_q[$];

    // Reference cursor and clear state
    int m_col = 0;
    int m_row = 0;
    bit m_clr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] wr_word(input int a, input logic [7:0] d);
        logic [12:0] a13;
        a13 = 13'(a);
        return {a13, d};
    endfunction

    // Scoreboard: every strobe must match the oldest expected write
    always @(negedge clk_in) begin
        if (rst_n_in) begin
            if (busy_out) busy_cnt++;
            if (busy_out && !wr_en_out) gap_cnt++;
            if (wr_en_out) begin
                if (exp_q.size() == 0) check("unexpected_wr", 32'(wr_en_out), 32'd0);
                else check("wr", 32'({wr_addr_out, wr_data_out}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic bus_cycle(input logic [1:0] a, input logic [7:0] d, input logic ce, input logic rw);
        address     = a;
        data_in     = d;
        chip_enable = ce;
        read_write  = rw;
        #100;
        ext_clock = 1'b1;
        #250;
        ext_clock = 1'b0;
        #250;
        chip_enable = 1'b0;
        read_write  = 1'b1;
        #($urandom_range(0, 24));
    endtask

    // Update the reference model, then drive the write on the bus
    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        int v;
        v = int'(d[6:0]);
        case (a)
            2'd0: m_col = (v > COLS - 1) ? COLS - 1 : v;
            2'd1: m_row = (v > ROWS - 1) ? ROWS - 1 : v;
            2'd2: if (!m_clr) begin
                exp_q.push_back(wr_word(m_row * COLS + m_col, d));
                m_col++;
                if (m_col == COLS) begin
                    m_col = 0;
                    m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
                end
            end
            default: if (!m_clr) begin
                if (d[0]) begin
                    for (int i = 0; i < COLS * ROWS; i++) exp_q.push_back(wr_word(i, 8'h20));
                    m_clr = 1;
                end else if (d[1]) begin
                    m_col = 0;
                    m_row = 0;
                end
            end
        endcase
        bus_cycle(a, d, 1'b1, 1'b0);
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_col"}, 32'(cursor_col_out), 32'(m_col));
        check({tag, "_row"}, 32'(cursor_row_out), 32'(m_row));
    endtask

    task automatic wait_clear_end();
        for (int k = 0; k < 10000 && busy_out; k++) @(negedge clk_in);
        check("clear_ends", 32'(busy_out), 32'd0);
        m_clr = 0;
        m_col = 0;
        m_row = 0;
        repeat (3) @(negedge clk_in);
    endtask

    initial begin
        #4ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit found;
        logic [7:0] d;

        repeat (3) @(negedge clk_in);
        check("rst_wr_en", 32'(wr_en_out), 32'd0);
        check("rst_wr_addr", 32'(wr_addr_out), 32'd0);
        check("rst_wr_data", 32'(wr_data_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check_cursor("rst");
        rst_n_in = 1'b1;
        repeat (3) @(negedge clk_in);

        // Basic character write at (5,3)
        cpu_write(2'd0, 8'd5);
        cpu_write(2'd1, 8'd3);
        cpu_write(2'd2, 8'h41);
        check_cursor("after_41");

        // Clamp, then ignored reads and deselected writes
        cpu_write(2'd0, 8'd120);
        cpu_write(2'd1, 8'd90);
        check_cursor("clamp");
        bus_cycle(2'd0, 8'd5, 1'b1, 1'b1);
        bus_cycle(2'd2, 8'h33, 1'b1, 1'b1);
        bus_cycle(2'd0, 8'd5, 1'b0, 1'b0);
        bus_cycle(2'd2, 8'h34, 1'b0, 1'b0);
        check_cursor("ignored");

        // Wrap from the last cell, then row advance
        cpu_write(2'd2, 8'h42);
        check_cursor("wrap");
        cpu_write(2'd0, 8'd99);
        cpu_write(2'd1, 8'd10);
        cpu_write(2'd2, 8'h43);
        check_cursor("row_adv");

        // Home control
        cpu_write(2'd3, 8'h02);
        check_cursor("home");

        // Full clear with a dropped character write inside it
        cpu_write(2'd0, 8'd17);
        busy_cnt = 0;
        gap_cnt  = 0;
        cpu_write(2'd3, 8'h03);
        cpu_write(2'd2, 8'h55);
        wait_clear_end();
        check("clear_busy_cycles", 32'(busy_cnt), 32'(COLS * ROWS));
        check("clear_gaps", 32'(gap_cnt), 32'd0);
        check("clear_drained", 32'(exp_q.size()), 32'd0);
        check_cursor("clear_home");

        // Latency: PHI2 falls 1.5 ns before a clk_in edge
        address     = 2'd2;
        data_in     = 8'h4C;
        chip_enable = 1'b1;
        read_write  = 1'b0;
        exp_q.push_back(wr_word(m_row * COLS + m_col, 8'h4C));
        m_col++;
        #100;
        ext_clock = 1'b1;
        repeat (10) @(posedge clk_in);
        @(negedge clk_in);
        #11;
        ext_clock = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk_in);
            #1;
            if (wr_en_out) begin
                lat = i;
                break;
            end
        end
        check("latency", 32'(lat), 32'd4);
        #250;
        chip_enable = 1'b0;
        read_write  = 1'b1;
        #100;

        // Random PHI2 phase over many writes: exactly one strobe each
        for (int n = 0; n < 1000; n++) begin
            d = 8'($urandom_range(0, 255));
            #($urandom_range(0, 24));
            cpu_write(2'd2, d);
        end
        repeat (10) @(negedge clk_in);
        check("random_drained", 32'(exp_q.size()), 32'd0);
        check_cursor("random");

        // Reset in the middle of a clear
        cpu_write(2'd0, 8'd7);
        cpu_write(2'd3, 8'h01);
        found = 0;
        for (int k = 0; k < 8000; k++) begin
            @(posedge clk_in);
            #1;
            if (wr_en_out && wr_addr_out == 13'd3000) begin
                found = 1;
                break;
            end
        end
        check("reached_3000", 32'(found), 32'd1);
        rst_n_in = 1'b0;
        #2;
        exp_q.delete();
        m_clr = 0;
        m_col = 0;
        m_row = 0;
        check("mid_rst_wr_en", 32'(wr_en_out), 32'd0);
        check("mid_rst_wr_addr", 32'(wr_addr_out), 32'd0);
        check("mid_rst_wr_data", 32'(wr_data_out), 32'd0);
        check("mid_rst_busy", 32'(busy_out), 32'd0);
        check_cursor("mid_rst");
        @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (20) @(negedge clk_in);
        check("post_rst_idle", 32'(busy_out), 32'd0);
        cpu_write(2'd2, 8'h61);
        repeat (5) @(negedge clk_in);
        check_cursor("post_rst");
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_char_writer.md
Name: bus_char_writer

Overview:
- 6502 bus slave that turns CPU register writes into write strobes for the text character buffer.
- The buffer is read by the letter generator on the 40 MHz pixel clock.
- Samples the asynchronous 6502 bus (address, data_in, chip_enable, read_write, ext_clock) into the clk_in domain and holds a text cursor.
- Emits one buffer write per character, plus a hardware screen-clear sequencer.

Parameters:
- COLS, 100, characters per row (800 px / 8 px font).
- ROWS, 75, character rows (600 px / 8 px font).
- ADDR_W, 13, buffer address width; must satisfy 2^ADDR_W >= COLS*ROWS.
- CLEAR_CHAR, 8'h20, code written to every cell during clear.

Ports:
- clk_in  input  1  40 MHz pixel-domain clock, from the PLL output.
- rst_n_in  input  1  asynchronous active-low reset.
- ext_clock  input  1  6502 PHI2, asynchronous to clk_in.
- chip_enable  input  1  active-high select for this block.
- read_write  input  1  6502 R/W: 1 = read, 0 = write.
- address  input  2  register select.
- data_in  input  8  CPU data bus.
- wr_addr_out  output  ADDR_W  buffer address = row*COLS + col.
- wr_data_out  output  8  character code.
- wr_en_out  output  1  one-cycle write strobe.
- busy_out  output  1  high while a clear is in progress.
- cursor_col_out  output  7  current column.
- cursor_row_out  output  7  current row.

Behaviour:
- Reset is asynchronous and active-low; one clock domain (clk_in).
- Reset values: all outputs 0, cursor (0,0), FSM in IDLE, all synchroniser flops 0.
- Synchronisation:
  - ext_clock, chip_enable, read_write, address and data_in each pass through a 2-flop synchroniser.
  - A third flop on synced PHI2 (phi_d) provides edge detection.
  - A bus hold register loads the synced ce/rw/addr/data on every cycle where synced PHI2 = 1.
  - bus_fall = phi_d & ~phi_sync.
  - A transaction is valid when bus_fall is high and the held ce = 1 and rw = 0.
  - Reads (rw = 1) and deselected cycles are ignored; no data is driven back.
- Register map (acted on in the cycle after bus_fall):
  - addr 0: column. Loads data[6:0]; values >= COLS clamp to COLS-1.
  - addr 1: row. Loads data[6:0]; values >= ROWS clamp to ROWS-1.
  - addr 2: character.
    - Drives wr_en_out = 1 for exactly one cycle, with wr_addr_out = row*COLS+col and wr_data_out = data.
    - The cursor advances in the same cycle: col+1; at col = COLS-1 it goes to col 0, row+1; at row = ROWS-1 with col = COLS-1 it wraps to (0,0).
  - addr 3: control.
    - bit0 = 1 starts a clear.
    - bit1 = 1 homes the cursor to (0,0).
    - If both are set, the clear wins; the cursor is homed at the end of the clear anyway.
- Latency: a bus write is seen on wr_en_out 4 clk_in cycles after the first clk_in edge that samples ext_clock low (2 sync, 1 edge detect, 1 output register).
- FSM states:
  - IDLE: serves register writes.
  - CLEAR:
    - Each cycle asserts wr_en_out with wr_data_out = CLEAR_CHAR and wr_addr_out = clr_cnt.
    - clr_cnt runs 0 .. COLS*ROWS-1; busy_out = 1 throughout.
    - After the write to COLS*ROWS-1: cursor goes to (0,0), busy_out drops, next state IDLE.
    - A clear takes exactly COLS*ROWS cycles (7500 at defaults).
- During CLEAR:
  - addr 2 writes are dropped (cursor unchanged).
  - addr 0/1 writes update the cursor, but the clear end still homes it.
  - addr 3 clear requests are ignored; no restart.
- Multiplier: row*COLS is computed combinationally from the registered cursor; wr_addr_out is registered.
- Reset asserted mid-clear aborts the clear immediately; all outputs go to reset values.
- A PHI2 pulse shorter than 2 clk_in periods is not guaranteed to register. A 1 MHz 6502 gives 20 cycles per phase.

Test Plan:
- Reset, then write addr0 = 5, addr1 = 3, addr2 = 8'h41 → single wr_en_out pulse with wr_addr_out = 305, wr_data_out = 8'h41; cursor afterwards (6,3).
- Cursor at (99,74), write addr2 = 8'h42 → write at address 7499, cursor wraps to (0,0); with the cursor at (99,10), the next write moves it to (0,11).
- Write addr0 = 120, addr1 = 90 → cursor clamps to (99,74); read cycles (rw = 1) and chip_enable = 0 writes produce no wr_en_out and no cursor change.
- Write addr3 = 8'h01 → busy_out high for 7500 cycles, 7500 consecutive wr_en_out pulses with addresses 0..7499 and data 8'h20, then cursor (0,0); an addr2 write issued mid-clear is dropped.
- Measure latency: ext_clock falling edge aligned just before a clk_in edge → wr_en_out asserted on the 4th clk_in edge; randomise PHI2 phase over 1000 writes and check exactly one strobe per write.
- Assert rst_n_in low for 1 cycle at clear cycle 3000 → outputs 0 asynchronously, busy_out 0, FSM IDLE; a subsequent addr2 write works normally at (0,0).
